// File: rtl/bram_loader.sv
// Write-port controller for the dual-port block RAM: zero-fills the array
// or loads words assembled little-endian from an 8-bit valid/ready stream.
module bram_loader #(
    parameter int SIZE       = 512,
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_clear,
    input  logic                  start_load,
    input  logic [ADDR_WIDTH-1:0] load_base,
    input  logic [ADDR_WIDTH:0]   load_len,
    input  logic                  s_valid,
    input  logic [7:0]            s_data,
    output logic                  s_ready,
    output logic                  ena,
    output logic                  wea,
    output logic [ADDR_WIDTH-1:0] addra,
    output logic [DATA_WIDTH-1:0] dia,
    output logic                  busy,
    output logic                  done
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int LW    = ADDR_WIDTH + 1;

    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(SIZE - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(BYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        LOAD
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [LW-1:0]           rem_q, rem_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   word_q, word_d;
    logic                    s_ready_q, s_ready_d;
    logic                    ena_q, ena_d;
    logic [ADDR_WIDTH-1:0]   addra_q, addra_d;
    logic [DATA_WIDTH-1:0]   dia_q, dia_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [LW-1:0]           len_clamped;

    assign len_clamped = (load_len > LW'(SIZE)) ? LW'(SIZE) : load_len;

    assign s_ready = s_ready_q;
    assign ena     = ena_q;
    assign wea     = ena_q;
    assign addra   = addra_q;
    assign dia     = dia_q;
    assign busy    = busy_q;
    assign done    = done_q;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        idx_d     = idx_q;
        word_d    = word_q;
        s_ready_d = 1'b0;
        ena_d     = 1'b0;
        addra_d   = addra_q;
        dia_d     = dia_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start_clear) begin
                    state_d = CLEAR;
                    busy_d  = 1'b1;
                    ena_d   = 1'b1;
                    addra_d = '0;
                    dia_d   = '0;
                end else if (start_load) begin
                    idx_d  = '0;
                    addr_d = load_base;
                    rem_d  = len_clamped;
                    if (len_clamped == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d   = LOAD;
                        busy_d    = 1'b1;
                        s_ready_d = 1'b1;
                    end
                end
            end
            CLEAR: begin
                // addra_q doubles as the clear counter
                if (addra_q == ADDR_LAST) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    ena_d   = 1'b1;
                    addra_d = addra_q + 1'b1;
                    dia_d   = '0;
                end
            end
            LOAD: begin
                if (rem_q == '0) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    s_ready_d = 1'b1;
                    if (s_valid && s_ready_q) begin
                        for (int b = 0; b < BYTES; b++) begin
                            if (idx_q == IDX_W'(b)) word_d[b*8 +: 8] = s_data;
                        end
                        idx_d = idx_q + 1'b1;
                        if (idx_q == IDX_LAST) begin
                            idx_d     = '0;
                            ena_d     = 1'b1;
                            addra_d   = addr_q;
                            dia_d     = word_d;
                            addr_d    = (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;
                            rem_d     = rem_q - 1'b1;
                            s_ready_d = (rem_q != LW'(1));
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            idx_q     <= '0;
            word_q    <= '0;
            s_ready_q <= 1'b0;
            ena_q     <= 1'b0;
            addra_q   <= '0;
            dia_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            idx_q     <= idx_d;
            word_q    <= word_d;
            s_ready_q <= s_ready_d;
            ena_q     <= ena_d;
            addra_q   <= addra_d;
            dia_q     <= dia_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_bram_loader.sv
// Bench for bram_loader: directed table of loads, clear/start-conflict
// sequences, reset mid-load and random loads against a word-list model.
module tb_bram_loader;

    localparam int SIZE = 512;
    localparam int AW   = 9;
    localparam int DW   = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start_clear;
    logic          start_load;
    logic [AW-1:0] load_base;
    logic [AW:0]   load_len;
    logic          s_valid;
    logic [7:0]    s_data;
    logic          s_ready;
    logic          ena;
    logic          wea;
    logic [AW-1:0] addra;
    logic [DW-1:0] dia;
    logic          busy;
    logic          done;

    bram_loader #(.SIZE(SIZE), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .start_clear(start_clear), .start_load(start_load),
        .load_base(load_base), .load_len(load_len),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .ena(ena), .wea(wea), .addra(addra), .dia(dia),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    typedef struct {
        logic [AW-1:0] base;
        logic [AW:0]   len;
        int            exp_words;
        logic [AW-1:0] exp_last;
        bit            ramp;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;

    wr_t        wlog[$];
    logic [7:0] stim[$];
    logic [DW-1:0] mem [SIZE];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Write-port scoreboard
    always @(posedge clk) begin
        #1;
        if (ena === 1'b1) begin
            wlog.push_back('{a: addra, d: dia});
            mem[addra] = dia;
        end
        if (reset === 1'b0) check("wea_eq_ena", {63'd0, wea}, {63'd0, ena});
    end

    task automatic run_load(input logic [AW-1:0] base, input logic [AW:0] len,
                            input int exp_words, input logic [AW-1:0] exp_last,
                            input bit ramp, input bit preset);
        int nb, idx, budget;
        bit pend;
        logic [DW-1:0] w;
        logic [AW-1:0] ea;
        nb = exp_words * 4;
        if (!preset) begin
            stim.delete();
            for (int i = 0; i < nb; i++)
                stim.push_back(ramp ? 8'(i + 1) : 8'($urandom));
        end
        wlog.delete();
        load_base  = base;
        load_len   = len;
        start_load = 1'b1;
        tick();
        start_load = 1'b0;
        load_base  = AW'($urandom);
        load_len   = '0;
        check("load_busy", {63'd0, busy}, {63'd0, exp_words != 0});
        check("load_ready", {63'd0, s_ready}, {63'd0, exp_words != 0});
        if (exp_words == 0) begin
            check("zero_len_done", {62'd0, done, ena}, 64'b10);
            tick();
            check("zero_len_idle", {done, busy, s_ready, ena}, 0);
            check("zero_len_writes", wlog.size(), 0);
        end else begin
            check("load_not_done", {63'd0, done}, 0);
            idx = 0;
            pend = 1'b0;
            budget = 0;
            while (idx < nb && budget < 20000) begin
                check("strobe_timing", {63'd0, ena}, {63'd0, pend});
                check("ready_high", {63'd0, s_ready}, 1);
                s_valid = ($urandom_range(0, 3) != 0);
                s_data  = s_valid ? stim[idx] : 8'($urandom);
                pend = 1'b0;
                if (s_valid && s_ready) begin
                    pend = (idx % 4 == 3);
                    idx++;
                end
                tick();
                budget++;
            end
            if (budget >= 20000) check("load_timeout", 0, 1);
            check("final_strobe", {63'd0, ena}, 1);
            check("ready_low_after_last", {63'd0, s_ready}, 0);
            check("done_not_early", {63'd0, done}, 0);
            s_valid = 1'b1;
            s_data  = 8'hEE;
            tick();
            check("load_done", {done, busy, ena, s_ready}, 4'b1000);
            s_valid = 1'b0;
            tick();
            check("done_one_cycle", {63'd0, done}, 0);
            check("write_count", wlog.size(), exp_words);
            for (int i = 0; i < exp_words && i < wlog.size(); i++) begin
                w  = DW'(stim[4*i]) + DW'(stim[4*i+1]) * 256 +
                     DW'(stim[4*i+2]) * 65536 + DW'(stim[4*i+3]) * 16777216;
                ea = AW'((int'(base) + i) % SIZE);
                check("write_addr", wlog[i].a, ea);
                check("write_data", wlog[i].d, w);
            end
            if (wlog.size() > 0) check("last_addr", wlog[$].a, exp_last);
        end
    endtask

    task automatic run_clear(input bit with_load, input bit late_load);
        int n, budget, nz;
        wlog.delete();
        start_clear = 1'b1;
        start_load  = with_load;
        load_base   = 9'h005;
        load_len    = 10'd2;
        tick();
        start_clear = 1'b0;
        start_load  = 1'b0;
        n = 0;
        budget = 0;
        while (ena === 1'b1 && budget < SIZE + 20) begin
            check("clear_addr", addra, n);
            check("clear_data", dia, 0);
            check("clear_busy_ready", {busy, s_ready, done}, 3'b100);
            n++;
            start_load = late_load && (n == 100);
            tick();
            budget++;
        end
        start_load = 1'b0;
        check("clear_strobes", n, SIZE);
        check("clear_done", {done, busy, ena, s_ready}, 4'b1000);
        tick();
        check("clear_after", {done, busy, ena, s_ready}, 0);
        tick();
        check("clear_no_load", {busy, ena, s_ready}, 0);
        check("clear_log", wlog.size(), SIZE);
        nz = 0;
        for (int i = 0; i < SIZE; i++) if (mem[i] !== '0) nz++;
        check("clear_mem_zero", nz, 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        vec_t tbl[6];
        logic [AW-1:0] rb;
        logic [AW:0]   rl;

        tbl[0] = '{9'h1FE, 10'd3,   3,   9'h000, 1'b1};
        tbl[1] = '{9'h010, 10'd0,   0,   9'h000, 1'b0};
        tbl[2] = '{9'h07F, 10'd1,   1,   9'h07F, 1'b0};
        tbl[3] = '{9'h1FF, 10'd2,   2,   9'h000, 1'b0};
        tbl[4] = '{9'h100, 10'd700, 512, 9'h0FF, 1'b0};
        tbl[5] = '{9'h000, 10'd512, 512, 9'h1FF, 1'b0};

        for (int i = 0; i < SIZE; i++) mem[i] = 32'hDEADBEEF;

        reset = 1'b1;
        start_clear = 1'b0;
        start_load = 1'b0;
        load_base = '0;
        load_len = '0;
        s_valid = 1'b0;
        s_data = '0;
        tick();
        for (int i = 0; i < 3; i++) begin
            check("reset_outputs", {s_ready, ena, wea, addra, dia, busy, done}, 0);
            start_clear = 1'($urandom);
            start_load  = 1'($urandom);
            load_base   = AW'($urandom);
            load_len    = (AW+1)'($urandom);
            s_valid     = 1'($urandom);
            s_data      = 8'($urandom);
            tick();
        end
        check("reset_outputs", {s_ready, ena, wea, addra, dia, busy, done}, 0);
        check("reset_no_strobe", wlog.size(), 0);
        reset = 1'b0;
        start_clear = 1'b0;
        start_load = 1'b0;
        s_valid = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_load(tbl[i].base, tbl[i].len, tbl[i].exp_words,
                     tbl[i].exp_last, tbl[i].ramp, 1'b0);
            if (i == 0) begin
                check("stall_word0", mem[9'h1FE], 32'h04030201);
                check("stall_word1", mem[9'h1FF], 32'h08070605);
                check("stall_word2", mem[9'h000], 32'h0C0B0A09);
            end
        end

        run_clear(1'b1, 1'b0);
        run_clear(1'b0, 1'b1);

        wlog.delete();
        load_base  = 9'h020;
        load_len   = 10'd1;
        start_load = 1'b1;
        tick();
        start_load = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'h11;
        tick();
        s_data  = 8'h22;
        tick();
        reset  = 1'b1;
        s_data = 8'h33;
        tick();
        check("mid_reset_outputs", {ena, s_ready, busy, done}, 0);
        reset   = 1'b0;
        s_valid = 1'b0;
        tick();
        check("post_reset_idle", {ena, s_ready, busy, done}, 0);
        check("mid_reset_no_write", wlog.size(), 0);
        stim.delete();
        stim.push_back(8'hDD);
        stim.push_back(8'hCC);
        stim.push_back(8'hBB);
        stim.push_back(8'hAA);
        run_load(9'h020, 10'd1, 1, 9'h020, 1'b0, 1'b1);
        check("no_stale_lanes", mem[9'h020], 32'hAABBCCDD);

        for (int k = 0; k < 8; k++) begin
            rb = AW'($urandom_range(0, SIZE - 1));
            rl = (AW+1)'($urandom_range(0, 24));
            run_load(rb, rl, int'(rl),
                     AW'((int'(rb) + int'(rl) + SIZE - 1) % SIZE), 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
